// File: rtl/segment_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : segment_scan_sequencer
// Brief    : 4-digit common-anode 7-segment scan controller with blanking gap,
//            frame-synchronous shadow latch and leading-zero suppression.
// Revision : 1.0 - initial release
// ============================================================================
module segment_scan_sequencer #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_suppress,
  output logic [3:0]  AN,
  output logic [7:0]  data_out,
  output logic        frame_done
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_idx, w_idx_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [15:0]   r_shadow;
  logic [3:0]    r_dp;
  logic          r_lz;
  logic          w_capture;
  logic          w_frame_end;
  logic [3:0]    w_nibble;
  logic          w_blank;
  logic [3:0]    w_an;
  logic [7:0]    w_seg;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'h40;
      4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;
      4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;
      4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;
      4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;
      4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;
      4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;
      4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;
      default: hex_decode = 7'h0E;
    endcase
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_capture   = 1'b0;
    w_frame_end = 1'b0;
    if (!ena) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = 2'd0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = BLANK;
          w_idx_nxt   = 2'd0;
          w_cnt_nxt   = '0;
          w_capture   = 1'b1;
        end
        BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt = DRIVE;
            w_cnt_nxt   = '0;
          end
        end
        DRIVE: begin
          if (r_cnt == DIGIT_LAST) begin
            w_state_nxt = BLANK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              w_frame_end = 1'b1;
              w_capture   = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_idx_nxt   = 2'd0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    w_nibble = r_shadow[{r_idx, 2'b00} +: 4];
    case (r_idx)
      2'd3:    w_blank = r_lz && (r_shadow[15:12] == 4'h0);
      2'd2:    w_blank = r_lz && (r_shadow[15:8]  == 8'h00);
      2'd1:    w_blank = r_lz && (r_shadow[15:4]  == 12'h000);
      default: w_blank = 1'b0;
    endcase
    w_an  = 4'hF;
    w_seg = 8'hFF;
    if (ena && (r_state == DRIVE)) begin
      w_an  = ~(4'b0001 << r_idx);
      w_seg = {~r_dp[r_idx], (w_blank ? 7'h7F : hex_decode(w_nibble))};
    end
  end

  // Pins show the slot the sequencer just finished, so frame_done lands on the final digit-3 cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= 2'd0;
      r_cnt      <= '0;
      r_shadow   <= 16'h0000;
      r_dp       <= 4'h0;
      r_lz       <= 1'b0;
      AN         <= 4'hF;
      data_out   <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      AN         <= w_an;
      data_out   <= w_seg;
      frame_done <= w_frame_end;
      if (w_capture) begin
        r_shadow <= data_in;
        r_dp     <= dp_in;
        r_lz     <= lz_suppress;
      end
    end
  end

endmodule
`default_nettype wire
